// File: rtl/add_sub_defs.sv
// Shared encodings for the sequential adder/subtractor.
package add_sub_defs;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/add_sub_chunk.sv
// CHUNK-bit combinational ripple slice; also exposes the carry into its MSB
// so the caller can derive signed overflow on the top slice.
module add_sub_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    fa u_fa (
      .a  (a[i]),
      .b  (y[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co       = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/fa.sv
// Single-bit full adder cell.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and majority carry.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/add_sub_seq.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock through a
// registered carry, with optional signed saturation and C/V/Z/N flags.
module add_sub_seq
  import add_sub_defs::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             cin,
  input  logic             sat,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_flag,
  output logic             v_flag,
  output logic             z_flag,
  output logic             n_flag
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CHUNK-1:0] CHUNK_MASK = {CHUNK{1'b1}};
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Reject parameter sets that cannot be sliced evenly.
  if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("add_sub_seq: illegal WIDTH/CHUNK combination");
  end

  state_e            state_q;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  y_q;
  logic              sat_q;
  logic              carry_q;
  logic [WIDTH-1:0]  result_q;
  logic              c_q, v_q, z_q, n_q;
  logic              out_valid_q;

  logic [CHUNK-1:0]  slice_a, slice_y, slice_s;
  logic              slice_co, slice_c_msb;
  logic [WIDTH-1:0]  sum_d;
  logic [WIDTH-1:0]  final_d;
  logic              v_d;
  logic              last_d;
  op_e               op_w;
  int unsigned       sh;

  assign op_w = op_e'(op);

  add_sub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a        (slice_a),
    .y        (slice_y),
    .ci       (carry_q),
    .s        (slice_s),
    .co       (slice_co),
    .c_msb_in (slice_c_msb)
  );

  // Select the active slice and merge its sum into the running result.
  always_comb begin
    sh      = 32'(idx_q) * CHUNK;
    slice_a = CHUNK'(a_q >> sh);
    slice_y = CHUNK'(y_q >> sh);
    sum_d   = (result_q & ~(WIDTH'(CHUNK_MASK) << sh)) | (WIDTH'(slice_s) << sh);
    last_d  = (idx_q == IDXW'(NCHUNK - 1));
    // Carry into vs. out of the MSB differ exactly on signed overflow.
    v_d     = slice_co ^ slice_c_msb;
    final_d = sum_d;
    if (sat_q && v_d) begin
      final_d = sum_d[WIDTH-1] ? SAT_POS : SAT_NEG;
    end
  end

  // Control FSM with operand latches, slice accumulation and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      y_q         <= '0;
      sat_q       <= 1'b0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            y_q     <= b ^ {WIDTH{op[0]}};
            sat_q   <= sat;
            carry_q <= (op_w == OP_ADC || op_w == OP_SBB) ? cin : op[0];
            idx_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          carry_q  <= slice_co;
          idx_q    <= idx_q + IDXW'(1);
          result_q <= sum_d;
          if (last_d) begin
            result_q    <= final_d;
            c_q         <= slice_co;
            v_q         <= v_d;
            z_q         <= (final_d == '0);
            n_q         <= final_d[WIDTH-1];
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign c_flag    = c_q;
  assign v_flag    = v_q;
  assign z_flag    = z_q;
  assign n_flag    = n_q;

endmodule
